switch_input_unit: RTL and testbench

- Per-ingress-port input unit for the chiplet switch, generalised to NUM_VCS virtual channels.
- Each VC has:
  - a DEPTH-flit FIFO;
  - a packet state machine that sequences route compute, VC allocation and active forwarding;
  - registered credit return to the upstream link.
- Sits between the link receive logic and the route-compute arbiter, VC allocator and switch allocator/crossbar.
- Replaces the fixed two-VC buffer split with a parametrised, packet-aware unit that supports rollback on allocation failure.

---
 rtl/switch_input_if.sv | 32 +++
 rtl/switch_input_unit.sv | 82 ++++++++
 tb/tb_switch_input_unit.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/switch_input_if.sv
// switch_input_if: link-receive and allocator-side signals of one switch input port.
interface switch_input_if #(
   parameter int NUM_VCS = 2,
   parameter int FLIT_WIDTH = 38,
   parameter int VC_W = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1
);
   logic                       in_valid;
   logic [VC_W-1:0]            in_vc;
   logic [FLIT_WIDTH-1:0]      in_flit;
   logic                       in_tail;
   logic [NUM_VCS-1:0]         credit_out;
   logic [NUM_VCS*FLIT_WIDTH-1:0] head_flit;
   logic [NUM_VCS-1:0]         empty;
   logic [NUM_VCS-1:0]         rc_req;
   logic [NUM_VCS-1:0]         rc_grant;
   logic [NUM_VCS-1:0]         va_grant;
   logic [NUM_VCS-1:0]         va_fail;
   logic [NUM_VCS*VC_W-1:0]    va_out_vc;
   logic [NUM_VCS-1:0]         active;
   logic [NUM_VCS*VC_W-1:0]    final_vc;
   logic [NUM_VCS-1:0]         pop;
   logic [NUM_VCS-1:0]         overflow_err;
   logic [NUM_VCS*16-1:0]      stat_flits;
   modport master (
      output in_valid, in_vc, in_flit, in_tail, rc_grant, va_grant, va_fail, va_out_vc, pop,
      input  credit_out, head_flit, empty, rc_req, active, final_vc, overflow_err, stat_flits
   );
   modport slave (
      input  in_valid, in_vc, in_flit, in_tail, rc_grant, va_grant, va_fail, va_out_vc, pop,
      output credit_out, head_flit, empty, rc_req, active, final_vc, overflow_err, stat_flits
   );
endinterface

// File: rtl/switch_input_unit.sv
// switch_input_unit: per-VC flit FIFOs with packet FSMs (RC -> VA -> ACTIVE) and credit return.
// Define SWITCH_INPUT_STATS_EN to add saturating per-VC forwarded-flit counters.
module switch_input_unit #(
   parameter int NUM_VCS = 2,
   parameter int DEPTH = 8,
   parameter int FLIT_WIDTH = 38,
   parameter int VC_W = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1
) (
   input logic clk,
   input logic n_rst,
   switch_input_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   typedef enum logic [1:0] {IDLE, RC, VA, ACTIVE} state_t;
   for (genvar v = 0; v < NUM_VCS; v++) begin : g_vc
      state_t                state, state_d;
      logic [FLIT_WIDTH-1:0] mem [DEPTH];
      logic [DEPTH-1:0]      tail_tag;
      logic [PTR_W-1:0]      rd_ptr, wr_ptr;
      logic [CNT_W-1:0]      cnt, cnt_d;
      logic                  wr, full, eff_pop, accept, credit, overflow;
      logic [VC_W-1:0]       out_vc;
      assign wr      = bus.in_valid && bus.in_vc == VC_W'(v);
      assign full    = cnt == CNT_W'(DEPTH);
      assign eff_pop = bus.pop[v] && state == ACTIVE && cnt != '0;
      // a full FIFO still accepts when the same cycle frees a slot
      assign accept  = wr && (!full || eff_pop);
      assign cnt_d   = cnt + CNT_W'(accept) - CNT_W'(eff_pop);
      always_ff @(posedge clk)
         if (accept) mem[wr_ptr] <= bus.in_flit;
      always_ff @(posedge clk) begin
         if (!n_rst) begin
            state    <= IDLE;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            cnt      <= '0;
            tail_tag <= '0;
            credit   <= 1'b0;
            out_vc   <= '0;
            overflow <= 1'b0;
         end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            credit <= eff_pop;
            if (accept) begin
               wr_ptr           <= wr_ptr + PTR_W'(1);
               tail_tag[wr_ptr] <= bus.in_tail;
            end
            if (eff_pop) rd_ptr <= rd_ptr + PTR_W'(1);
            if (state == VA && bus.va_grant[v]) out_vc <= bus.va_out_vc[v*VC_W +: VC_W];
            if (wr && full && !eff_pop) overflow <= 1'b1;
         end
      end
      always_comb begin
         state_d = state;
         case (state)
            IDLE:    state_d = (cnt != '0) ? RC : IDLE;
            RC:      state_d = bus.rc_grant[v] ? VA : RC;
            VA:      state_d = bus.va_grant[v] ? ACTIVE : bus.va_fail[v] ? RC : VA;
            default: state_d = (eff_pop && tail_tag[rd_ptr]) ? ((cnt_d != '0) ? RC : IDLE) : ACTIVE;
         endcase
      end
      assign bus.head_flit[v*FLIT_WIDTH +: FLIT_WIDTH] = mem[rd_ptr];
      assign bus.empty[v]                  = cnt == '0;
      assign bus.rc_req[v]                 = state == RC;
      assign bus.active[v]                 = state == ACTIVE;
      assign bus.credit_out[v]             = credit;
      assign bus.final_vc[v*VC_W +: VC_W]  = out_vc;
      assign bus.overflow_err[v]           = overflow;
`ifdef SWITCH_INPUT_STATS_EN
      logic [15:0] stat;
      always_ff @(posedge clk) begin
         if (!n_rst) stat <= '0;
         else if (eff_pop && stat != 16'hFFFF) stat <= stat + 16'd1;
      end
      assign bus.stat_flits[v*16 +: 16] = stat;
`else
      assign bus.stat_flits[v*16 +: 16] = 16'd0;
`endif
   end
endmodule

// File: tb/tb_switch_input_unit.sv
// tb_switch_input_unit: scoreboard bench; a behavioural per-VC model predicts every output each cycle.
module tb_switch_input_unit;
   localparam int NV = 2;
   localparam int D  = 8;
   localparam int FW = 38;
   localparam int VW = 1;
   logic clk = 1'b0;
   logic n_rst = 1'b0;
   always #5 clk = ~clk;
   switch_input_if #(.NUM_VCS(NV), .FLIT_WIDTH(FW), .VC_W(VW)) bus ();
   switch_input_unit #(.NUM_VCS(NV), .DEPTH(D), .FLIT_WIDTH(FW), .VC_W(VW)) dut (
      .clk(clk), .n_rst(n_rst), .bus(bus)
   );
   int errs = 0;
   int checks = 0;
   logic [FW:0]    sbq [NV][$];
   int             mst [NV];
   logic [VW-1:0]  mfv [NV];
   logic [15:0]    mstat [NV];
   logic [NV-1:0]  movf = '0;
   logic [NV-1:0]  exp_cred = '0;
   int             cred_cnt [NV];
   task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask
   function automatic logic [FW-1:0] rnd();
      logic [63:0] r;
      r = {$urandom, $urandom};
      return r[FW-1:0];
   endfunction
   task automatic check_outputs();
      logic [NV-1:0] rc, ac, em;
      logic [NV*VW-1:0] fv;
      logic [NV*16-1:0] st;
      logic [FW:0] e;
      for (int v = 0; v < NV; v++) begin
         rc[v] = mst[v] == 1;
         ac[v] = mst[v] == 3;
         em[v] = sbq[v].size() == 0;
         fv[v*VW +: VW] = mfv[v];
`ifdef SWITCH_INPUT_STATS_EN
         st[v*16 +: 16] = mstat[v];
`else
         st[v*16 +: 16] = 16'd0;
`endif
      end
      check("credit_out", bus.credit_out, exp_cred);
      check("rc_req", bus.rc_req, rc);
      check("active", bus.active, ac);
      check("empty", bus.empty, em);
      check("overflow_err", bus.overflow_err, movf);
      check("final_vc", bus.final_vc, fv);
      check("stat_flits", bus.stat_flits, st);
      for (int v = 0; v < NV; v++)
         if (!em[v]) begin
            e = sbq[v][0];
            check("head_flit", bus.head_flit[v*FW +: FW], e[FW-1:0]);
         end
   endtask
   // Advance one clock: predict from the inputs, clock the DUT, compare, clear one-shot inputs.
   task automatic tick();
      logic [NV-1:0] eff;
      int ns [NV];
      logic [FW:0] e;
      for (int v = 0; v < NV; v++) begin
         int sz;
         sz = sbq[v].size();
         e = '0;
         eff[v] = bus.pop[v] && mst[v] == 3 && sz != 0;
         ns[v] = mst[v];
         case (mst[v])
            0: if (sz != 0) ns[v] = 1;
            1: if (bus.rc_grant[v]) ns[v] = 2;
            2: if (bus.va_grant[v]) begin
                  ns[v] = 3;
                  if (n_rst) mfv[v] = bus.va_out_vc[v*VW +: VW];
               end else if (bus.va_fail[v]) ns[v] = 1;
            default: ;
         endcase
         if (n_rst && eff[v]) begin
            e = sbq[v].pop_front();
            check("pop_data", bus.head_flit[v*FW +: FW], e[FW-1:0]);
            if (mstat[v] != 16'hFFFF) mstat[v]++;
         end
         if (n_rst && bus.in_valid && bus.in_vc == VW'(v)) begin
            if (sz < D || eff[v]) sbq[v].push_back({bus.in_tail, bus.in_flit});
            else movf[v] = 1'b1;
         end
         if (eff[v] && e[FW]) ns[v] = (sbq[v].size() != 0) ? 1 : 0;
      end
      @(posedge clk);
      #1;
      if (!n_rst) begin
         for (int v = 0; v < NV; v++) begin
            sbq[v].delete();
            mst[v] = 0;
            mfv[v] = '0;
            mstat[v] = '0;
         end
         movf = '0;
         exp_cred = '0;
      end else begin
         for (int v = 0; v < NV; v++) mst[v] = ns[v];
         exp_cred = eff;
      end
      for (int v = 0; v < NV; v++) if (bus.credit_out[v]) cred_cnt[v]++;
      bus.in_valid = 1'b0;
      bus.rc_grant = '0;
      bus.va_grant = '0;
      bus.va_fail  = '0;
      bus.pop      = '0;
      check_outputs();
   endtask
   task automatic do_reset();
      n_rst = 1'b0;
      tick();
      check("rst_empty", bus.empty, {NV{1'b1}});
      n_rst = 1'b1;
      for (int v = 0; v < NV; v++) cred_cnt[v] = 0;
   endtask
   task automatic wr(int v, logic [FW-1:0] f, logic t);
      bus.in_valid = 1'b1;
      bus.in_vc = VW'(v);
      bus.in_flit = f;
      bus.in_tail = t;
      tick();
   endtask
   task automatic wait_rc(int v);
      for (int i = 0; i < 8 && mst[v] != 1; i++) tick();
      check("rc_wait", bus.rc_req[v], 1);
   endtask
   task automatic alloc(int v, logic [VW-1:0] ovc);
      wait_rc(v);
      bus.rc_grant[v] = 1'b1;
      tick();
      bus.va_grant[v] = 1'b1;
      bus.va_out_vc[v*VW +: VW] = ovc;
      tick();
      check("alloc_active", bus.active[v], 1);
   endtask
   task automatic pop_n(int v, int n);
      for (int i = 0; i < n; i++) begin
         bus.pop[v] = 1'b1;
         tick();
      end
   endtask
   initial begin
      bus.in_valid = 1'b0;
      bus.in_vc = '0;
      bus.in_flit = '0;
      bus.in_tail = 1'b0;
      bus.rc_grant = '0;
      bus.va_grant = '0;
      bus.va_fail = '0;
      bus.va_out_vc = '0;
      bus.pop = '0;
      for (int v = 0; v < NV; v++) begin
         mst[v] = 0;
         mfv[v] = '0;
         mstat[v] = '0;
         cred_cnt[v] = 0;
      end
      do_reset();
      // single-flit packet on VC1
      wr(1, rnd(), 1'b1);
      check("t1_empty1", bus.empty[1], 0);
      tick();
      check("t1_rc_req1", bus.rc_req[1], 1);
      alloc(1, 1'b0);
      check("t1_final_vc1", bus.final_vc[1], 0);
      pop_n(1, 1);
      check("t1_credit1", bus.credit_out[1], 1);
      check("t1_empty_after", bus.empty[1], 1);
      tick();
      check("t1_credit_once", cred_cnt[1], 1);
      // fill VC0 past capacity, then write while popping a full FIFO
      do_reset();
      for (int i = 0; i < D + 1; i++) wr(0, rnd(), 1'b0);
      check("t2_overflow", bus.overflow_err[0], 1);
      alloc(0, 1'b0);
      bus.in_valid = 1'b1;
      bus.in_vc = '0;
      bus.in_flit = rnd();
      bus.in_tail = 1'b0;
      bus.pop[0] = 1'b1;
      tick();
      check("t2_still_full", bus.empty[0], 0);
      pop_n(0, D);
      check("t2_drained", bus.empty[0], 1);
      pop_n(0, 1);
      check("t2_active_empty_no_credit", bus.credit_out[0], 0);
      check("t2_holds_active", bus.active[0], 1);
      // VA retry and grant-beats-fail
      do_reset();
      wr(0, rnd(), 1'b1);
      wait_rc(0);
      bus.rc_grant[0] = 1'b1;
      tick();
      bus.va_fail[0] = 1'b1;
      tick();
      check("t3_rc_again", bus.rc_req[0], 1);
      bus.rc_grant[0] = 1'b1;
      tick();
      bus.va_grant[0] = 1'b1;
      bus.va_out_vc[0] = 1'b1;
      tick();
      check("t3_final_vc0", bus.final_vc[0], 1);
      pop_n(0, 1);
      check("t3_final_hold", bus.final_vc[0], 1);
      wr(0, rnd(), 1'b1);
      wait_rc(0);
      bus.rc_grant[0] = 1'b1;
      tick();
      bus.va_grant[0] = 1'b1;
      bus.va_fail[0] = 1'b1;
      bus.va_out_vc[0] = 1'b0;
      tick();
      check("t3_grant_wins", bus.active[0], 1);
      pop_n(0, 1);
      // two 3-flit packets on VC0 with concurrent VC1 traffic
      do_reset();
      for (int i = 0; i < 6; i++) wr(0, rnd(), i == 2 || i == 5);
      wr(1, rnd(), 1'b0);
      wr(1, rnd(), 1'b1);
      alloc(0, 1'b1);
      alloc(1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         bus.pop[0] = 1'b1;
         bus.pop[1] = i < 2;
         tick();
      end
      check("t4_next_pkt_rc", bus.rc_req[0], 1);
      check("t4_vc1_idle", bus.active[1], 0);
      alloc(0, 1'b0);
      pop_n(0, 3);
      check("t4_credits0", cred_cnt[0], 6);
      check("t4_credits1", cred_cnt[1], 2);
      // pops outside ACTIVE are ignored
      do_reset();
      pop_n(0, 1);
      bus.in_valid = 1'b1;
      bus.in_vc = '0;
      bus.in_flit = rnd();
      bus.in_tail = 1'b0;
      bus.pop[0] = 1'b1;
      tick();
      pop_n(0, 1);
      bus.rc_grant[0] = 1'b1;
      pop_n(0, 1);
      pop_n(0, 1);
      check("t5_no_credit", cred_cnt[0], 0);
      bus.va_grant[0] = 1'b1;
      tick();
      pop_n(0, 2);
      check("t5_one_credit", cred_cnt[0], 1);
      wr(0, rnd(), 1'b1);
      pop_n(0, 1);
      check("t5_idle", bus.active[0], 0);
      // forwarded-flit counters
      do_reset();
      for (int i = 0; i < 5; i++) wr(1, rnd(), i == 4);
      alloc(1, 1'b0);
      pop_n(1, 5);
`ifdef SWITCH_INPUT_STATS_EN
      check("t6_stat5", bus.stat_flits[31:16], 5);
      wr(1, rnd(), 1'b0);
      alloc(1, 1'b1);
      for (int i = 0; i < 65540; i++) begin
         bus.in_valid = 1'b1;
         bus.in_vc = 1'b1;
         bus.in_flit = rnd();
         bus.in_tail = 1'b0;
         bus.pop[1] = 1'b1;
         tick();
      end
      check("t6_saturated", bus.stat_flits[31:16], 16'hFFFF);
`else
      check("t6_stat_zero", bus.stat_flits, 0);
`endif
      // reset in the middle of a packet
      for (int i = 0; i < 3; i++) wr(0, rnd(), 1'b0);
      wr(1, rnd(), 1'b0);
      alloc(0, 1'b1);
      bus.pop[0] = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_vc = '0;
      bus.in_flit = rnd();
      do_reset();
      check("t7_active", bus.active, 0);
      check("t7_final_vc", bus.final_vc, 0);
      tick();
      check("t7_stays_idle", bus.rc_req, 0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
